axis_pkt_len_tagger: RTL and testbench



---
 rtl/axis_pkt_len_tagger.sv | 129 ++++++++++++
 tb/tb_axis_pkt_len_tagger.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_len_tagger.sv
// axis_pkt_len_tagger: registered AXI-Stream pass-through that counts the
// valid words of each packet, emits the count on a side stream, checks tkeep.
module axis_pkt_len_tagger #(
  parameter int WORD_W = 8,
  parameter int WORDS  = 4,
  parameter int LEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORDS*WORD_W-1:0]   s_axis_tdata,
  input  logic [WORDS-1:0]          s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [WORDS*WORD_W-1:0]   m_axis_tdata,
  output logic [WORDS-1:0]          m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [LEN_W-1:0]          m_len_tdata,
  output logic                      m_len_tvalid,
  input  logic                      m_len_tready,
  output logic                      err_keep,
  output logic                      err_ovf
);

  localparam logic [LEN_W:0] MAX = {1'b0, {LEN_W{1'b1}}};

  logic [WORDS*WORD_W-1:0] data_q;
  logic [WORDS-1:0]        keep_q;
  logic                    last_q;
  logic                    vld_q;
  logic [LEN_W-1:0]        len_q;
  logic                    len_vld_q;
  logic [LEN_W:0]          acc_q;
  logic [LEN_W:0]          acc_d;
  logic                    ekeep_q;
  logic                    eovf_q;

  logic [LEN_W:0]          pcnt;
  logic [LEN_W:0]          sum;
  logic                    clamp;
  logic [WORDS-1:0]        keep_p1;
  logic                    keep_ok;
  logic                    fire;

  // Words in this beat: popcount of tkeep.
  always_comb begin
    pcnt = '0;
    for (int k = 0; k < WORDS; k++) begin
      pcnt = pcnt + (LEN_W+1)'(s_axis_tkeep[k]);
    end
  end

  // Running sum, clamped to the largest reportable length.
  always_comb begin
    sum   = acc_q + pcnt;
    clamp = (sum > MAX);
    acc_d = clamp ? MAX : sum;
  end

  // Last beat needs a nonzero run of ones from bit 0; others need all ones.
  always_comb begin
    keep_p1 = s_axis_tkeep + WORDS'(1);
    if (s_axis_tlast) begin
      keep_ok = (|s_axis_tkeep) &&
                ((s_axis_tkeep & keep_p1) == '0);
    end else begin
      keep_ok = &s_axis_tkeep;
    end
  end

  assign s_axis_tready = !rst &&
                         (!vld_q || m_axis_tready) &&
                         (!s_axis_tlast || !len_vld_q ||
                          m_len_tready);
  assign fire = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tvalid = vld_q;
  assign m_len_tdata   = len_q;
  assign m_len_tvalid  = len_vld_q;
  assign err_keep      = ekeep_q;
  assign err_ovf       = eovf_q;

  // Output beat register, length slot, accumulator and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
      vld_q     <= 1'b0;
      len_q     <= '0;
      len_vld_q <= 1'b0;
      acc_q     <= '0;
      ekeep_q   <= 1'b0;
      eovf_q    <= 1'b0;
    end else begin
      if (m_axis_tready) begin
        vld_q <= 1'b0;
      end
      if (m_len_tready) begin
        len_vld_q <= 1'b0;
      end
      if (fire) begin
        data_q <= s_axis_tdata;
        keep_q <= s_axis_tkeep;
        last_q <= s_axis_tlast;
        vld_q  <= 1'b1;
        if (!keep_ok) begin
          ekeep_q <= 1'b1;
        end
        if (clamp) begin
          eovf_q <= 1'b1;
        end
        if (s_axis_tlast) begin
          len_q     <= acc_d[LEN_W-1:0];
          len_vld_q <= 1'b1;
          acc_q     <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_len_tagger.sv
// tb_axis_pkt_len_tagger: random and directed packets against a
// packet-level model; a second instance with 4-bit lengths covers saturation.
module tb_axis_pkt_len_tagger;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata = '0;
  logic [3:0]    s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready, s4_tready;
  logic [DW-1:0] m_tdata, m4_tdata;
  logic [3:0]    m_tkeep, m4_tkeep;
  logic          m_tlast, m4_tlast;
  logic          m_tvalid, m4_tvalid;
  logic          m_tready = 1'b1;
  logic [15:0]   m_len_tdata;
  logic [3:0]    m4_len_tdata;
  logic          m_len_tvalid, m4_len_tvalid;
  logic          m_len_tready = 1'b1;
  logic          err_keep, err_ovf, e4_keep, e4_ovf;

  axis_pkt_len_tagger #(.WORD_W(8), .WORDS(4), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_len_tdata(m_len_tdata), .m_len_tvalid(m_len_tvalid),
    .m_len_tready(m_len_tready),
    .err_keep(err_keep), .err_ovf(err_ovf)
  );

  axis_pkt_len_tagger #(.WORD_W(8), .WORDS(4), .LEN_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s4_tready),
    .m_axis_tdata(m4_tdata), .m_axis_tkeep(m4_tkeep),
    .m_axis_tlast(m4_tlast), .m_axis_tvalid(m4_tvalid),
    .m_axis_tready(m_tready),
    .m_len_tdata(m4_len_tdata), .m_len_tvalid(m4_len_tvalid),
    .m_len_tready(m_len_tready),
    .err_keep(e4_keep), .err_ovf(e4_ovf)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [3:0]    k;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    len16_q[$];
  int    len4_q[$];
  beat_t mb;
  int    words = 0;
  bit    x_keep = 0, x_ovf16 = 0, x_ovf4 = 0;
  bit    stall_en = 0;
  int    n_last_out = 0, n_len_out = 0;
  int    n_chk = 0, n_fail = 0;
  int    cyc = 0, acc_cyc = 0, n_acc = 0;
  logic [7:0] rv = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: handshakes sampled mid-cycle, before the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tlast)
        check("len_sync", 64'(n_len_out + int'(m_len_tvalid)),
              64'(n_last_out + 1));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexp_beat", m_tvalid, 1'b0);
        end else begin
          mb = exp_q.pop_front();
          check("data", m_tdata, mb.d);
          check("keep", m_tkeep, mb.k);
          check("last", m_tlast, mb.l);
          check("data4", {m4_tvalid, m4_tdata}, {1'b1, mb.d});
          if (m_tlast) n_last_out++;
        end
      end
      if (m_len_tvalid && m_len_tready) begin
        if (len16_q.size() == 0) begin
          check("unexp_len", m_len_tvalid, 1'b0);
        end else begin
          check("len16", m_len_tdata, len16_q.pop_front());
          check("len4", {m4_len_tvalid, m4_len_tdata},
                {1'b1, 4'(len4_q.pop_front())});
        end
        n_len_out++;
      end
    end
  end

  // Random output backpressure, about 20% stall.
  always @(posedge clk) begin
    if (stall_en) begin
      #1;
      m_tready     = ($urandom_range(0, 4) != 0);
      m_len_tready = ($urandom_range(0, 4) != 0);
    end
  end

  task automatic send_beat(input logic [DW-1:0] d,
                           input logic [3:0] k, input logic l);
    int t = 0;
    if (stall_en) begin
      while ($urandom_range(0, 4) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) begin
      check("accept_timeout", s_tready, 1'b1);
    end else begin
      exp_q.push_back('{d, k, l});
      n_acc++;
      acc_cyc = cyc;
      words += $countones(k);
      if (l ? !(k inside {4'h1, 4'h3, 4'h7, 4'hF}) : (k != 4'hF))
        x_keep = 1;
      if (words > 65535) x_ovf16 = 1;
      if (words > 15) x_ovf4 = 1;
      if (l) begin
        len16_q.push_back(words > 65535 ? 65535 : words);
        len4_q.push_back(words > 15 ? 15 : words);
        words = 0;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit ramp);
    int nb = (n + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      int rem = n - 4 * i;
      logic [3:0] k;
      logic [DW-1:0] d;
      k = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
      if (ramp) begin
        d = {8'(rv + 3), 8'(rv + 2), 8'(rv + 1), rv};
        rv = 8'(rv + 4);
      end else begin
        d = $urandom;
      end
      send_beat(d, k, i == nb - 1);
    end
  endtask

  task automatic drain();
    int t = 0;
    stall_en = 0;
    @(posedge clk); #1;
    m_tready = 1'b1;
    m_len_tready = 1'b1;
    while ((exp_q.size() + len16_q.size()) != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if ((exp_q.size() + len16_q.size()) != 0)
      check("drain", 64'(exp_q.size() + len16_q.size()), 64'd0);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ekeep"}, {e4_keep, err_keep}, {x_keep, x_keep});
    check({tag, "_eovf"}, err_ovf, x_ovf16);
    check({tag, "_eovf4"}, e4_ovf, x_ovf4);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", m_tvalid, 1'b0);
    check("rst_lvalid", m_len_tvalid, 1'b0);
    check("rst_sready", {s4_tready, s_tready}, 2'b00);
    check("rst_regs", {m_tdata, m_tkeep, m_tlast, m_len_tdata}, 64'd0);
    check_flags("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Lengths 1..20, ramp data, full rate.
    send_pkt(1, 1);
    c1 = acc_cyc;
    b1 = n_acc;
    for (int n = 2; n <= 20; n++) send_pkt(n, 1);
    check("full_rate", 64'(acc_cyc - c1), 64'(n_acc - b1));
    drain();
    check_flags("basic");

    // Length slot backpressure: second last beat must wait.
    m_len_tready = 1'b0;
    send_pkt(5, 0);
    fork
      send_pkt(5, 0);
      begin
        repeat (6) @(negedge clk);
        check("bp_sready", s_tready, 1'b0);
        check("bp_waiting", {s_tvalid, s_tlast}, 2'b11);
        check("bp_len_hold", {m_len_tvalid, m_len_tdata}, {1'b1, 16'd5});
        @(posedge clk); #1;
        m_len_tready = 1'b1;
      end
    join
    drain();

    // Illegal keep patterns.
    send_beat($urandom, 4'h7, 1'b0);
    send_beat($urandom, 4'hF, 1'b1);
    drain();
    check_flags("ill_nonlast");
    send_beat($urandom, 4'h5, 1'b1);
    send_beat($urandom, 4'h0, 1'b1);
    drain();
    check_flags("ill_last");

    // Reset after 2 of 4 beats.
    send_beat($urandom, 4'hF, 1'b0);
    send_beat($urandom, 4'hF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sready", s_tready, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_out",
          {m_tvalid, m_len_tvalid, err_keep, err_ovf, e4_ovf}, 64'd0);
    check("mid_rst_regs",
          {m_tdata, m_tkeep, m_tlast, m_len_tdata}, 64'd0);
    exp_q.delete();
    len16_q.delete();
    len4_q.delete();
    words = 0;
    x_keep = 0; x_ovf16 = 0; x_ovf4 = 0;
    n_last_out = 0; n_len_out = 0;
    rst = 1'b0;
    send_pkt(6, 0);
    drain();
    check_flags("post_rst");

    // Saturation on the 4-bit instance: 20 words then 3.
    send_pkt(20, 0);
    drain();
    check_flags("sat");
    send_pkt(3, 0);
    drain();

    // Random sizes with random stalls everywhere.
    stall_en = 1;
    for (int p = 0; p < 100; p++) begin
      send_pkt($urandom_range(1, 24), 0);
    end
    drain();
    check_flags("rand");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
